// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue/collect sequencer: opcode encodings,
// flag bit positions, default widths and the opcode legality check.
package alu_sequencer_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FLAG_W = 4;

    // Flag bit positions inside a {C,S,O,Z} vector
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 1;
    localparam int unsigned FLAG_Z = 0;

    // Opcode encodings understood by the ALU
    localparam logic [OP_W-1:0] OP_NOP = 5'h00;
    localparam logic [OP_W-1:0] OP_NOT = 5'h01;
    localparam logic [OP_W-1:0] OP_AND = 5'h02;
    localparam logic [OP_W-1:0] OP_OR  = 5'h03;
    localparam logic [OP_W-1:0] OP_NEG = 5'h04;
    localparam logic [OP_W-1:0] OP_ADD = 5'h05;
    localparam logic [OP_W-1:0] OP_SUB = 5'h06;
    localparam logic [OP_W-1:0] OP_HLT = 5'h1F;

    // ALU status flags as carried on the response bus
    typedef struct packed {
        logic c;
        logic s;
        logic o;
        logic z;
    } alu_flags_t;

    // True for every opcode the ALU implements, HLT included
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_NOP, OP_NOT, OP_AND, OP_OR,
            OP_NEG, OP_ADD, OP_SUB, OP_HLT: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Issue/collect front-end for the combinational ALU: accepts one instruction
// over valid/ready, drives the ALU from registers, captures the result one
// cycle later and returns it over a valid/ready response handshake.
// Optional build macro ALU_SEQ_CHAIN_EN adds a chain register so an
// instruction can take operand A from the previous legal non-NOP result.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_chain,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_c,
    input  logic             alu_s,
    input  logic             alu_o,
    input  logic             alu_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic [3:0]       flags_q,
    output logic [CNTW-1:0]  op_count,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    alu_flags_t       out_flags_q, out_flags_d;
    logic             out_err_q, out_err_d;
    alu_flags_t       flags_arch_q, flags_arch_d;
    logic [CNTW-1:0]  op_count_q, op_count_d;
    logic             halted_q, halted_d;
    // Tags carried with the instruction in flight
    logic             err_tag_q, err_tag_d;
    logic             upd_tag_q, upd_tag_d;
    logic [3:0]       alu_flags_in;
    logic             accept_legal;
    logic             accept_hlt;

`ifdef ALU_SEQ_CHAIN_EN
    logic [WIDTH-1:0] chain_q, chain_d;
`else
    logic             chain_unused;
    assign chain_unused = in_chain;
`endif

    // Gather the ALU flag pins into {C,S,O,Z} order
    always_comb begin
        alu_flags_in         = 4'b0000;
        alu_flags_in[FLAG_C] = alu_c;
        alu_flags_in[FLAG_S] = alu_s;
        alu_flags_in[FLAG_O] = alu_o;
        alu_flags_in[FLAG_Z] = alu_z;
    end

    assign accept_hlt   = (OP_W'(in_op) == OP_HLT);
    assign accept_legal = op_is_legal(OP_W'(in_op)) && (OPW'(OP_W'(in_op)) == in_op);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        out_valid_d  = out_valid_q;
        out_r_d      = out_r_q;
        out_flags_d  = out_flags_q;
        out_err_d    = out_err_q;
        flags_arch_d = flags_arch_q;
        op_count_d   = op_count_q;
        halted_d     = halted_q;
        err_tag_d    = err_tag_q;
        upd_tag_d    = upd_tag_q;
`ifdef ALU_SEQ_CHAIN_EN
        chain_d      = chain_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (accept_legal && accept_hlt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else if (accept_legal) begin
                        alu_opcode_d = in_op;
`ifdef ALU_SEQ_CHAIN_EN
                        alu_a_d      = in_chain ? chain_q : in_a;
`else
                        alu_a_d      = in_a;
`endif
                        alu_b_d      = in_b;
                        err_tag_d    = 1'b0;
                        upd_tag_d    = (OP_W'(in_op) != OP_NOP);
                        state_d      = ST_EXEC;
                    end else begin
                        alu_opcode_d = OPW'(OP_NOP);
                        err_tag_d    = 1'b1;
                        upd_tag_d    = 1'b0;
                        state_d      = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                out_valid_d = 1'b1;
                if (err_tag_q) begin
                    out_r_d     = '0;
                    out_flags_d = '0;
                    out_err_d   = 1'b1;
                end else begin
                    out_r_d     = alu_r;
                    out_flags_d = alu_flags_t'(alu_flags_in);
                    out_err_d   = 1'b0;
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNTW'(1);
                    if (upd_tag_q) begin
                        flags_arch_d = out_flags_q;
`ifdef ALU_SEQ_CHAIN_EN
                        chain_d      = out_r_q;
`endif
                    end
                    state_d = ST_IDLE;
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            alu_opcode_q <= OPW'(OP_NOP);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_r_q      <= '0;
            out_flags_q  <= '0;
            out_err_q    <= 1'b0;
            flags_arch_q <= '0;
            op_count_q   <= '0;
            halted_q     <= 1'b0;
            err_tag_q    <= 1'b0;
            upd_tag_q    <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            out_valid_q  <= out_valid_d;
            out_r_q      <= out_r_d;
            out_flags_q  <= out_flags_d;
            out_err_q    <= out_err_d;
            flags_arch_q <= flags_arch_d;
            op_count_q   <= op_count_d;
            halted_q     <= halted_d;
            err_tag_q    <= err_tag_d;
            upd_tag_q    <= upd_tag_d;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q      <= chain_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_valid  = out_valid_q;
    assign out_r      = out_r_q;
    assign out_flags  = out_flags_q;
    assign out_err    = out_err_q;
    assign flags_q    = flags_arch_q;
    assign op_count   = op_count_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to its
// ALU-side ports. Honours ALU_SEQ_CHAIN_EN for the chained-operand step.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_chain;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_r;
    logic        alu_c, alu_s, alu_o, alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [3:0]  out_flags;
    logic        out_err;
    logic [3:0]  flags_q;
    logic [15:0] op_count;
    logic        halted;

    int checks;
    int passes;
    int fails;

    alu_sequencer #(.WIDTH(32), .OPW(5), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_chain(in_chain),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r), .alu_c(alu_c), .alu_s(alu_s), .alu_o(alu_o), .alu_z(alu_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_flags(out_flags), .out_err(out_err),
        .flags_q(flags_q), .op_count(op_count), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational ALU
    always_comb begin
        logic [32:0] sum;
        sum   = 33'd0;
        alu_r = 32'd0;
        alu_c = 1'b0;
        alu_o = 1'b0;
        case (alu_opcode)
            5'h01: alu_r = ~alu_a;
            5'h02: alu_r = alu_a & alu_b;
            5'h03: alu_r = alu_a | alu_b;
            5'h04: alu_r = 32'd0 - alu_a;
            5'h05: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r = sum[31:0];
                alu_c = sum[32];
                alu_o = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            5'h06: begin
                alu_r = alu_a - alu_b;
                alu_c = (alu_a < alu_b);
                alu_o = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            default: alu_r = 32'd0;
        endcase
        alu_s = alu_r[31];
        alu_z = (alu_r == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ch);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_chain = ch;
        step();
        in_valid = 1'b0;
        in_chain = 1'b0;
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 5'h0; in_a = 32'h0; in_b = 32'h0;
        in_chain = 1'b0; out_ready = 1'b1;
        step(); step();

        // Reset state
        check("rst_in_ready",  32'(in_ready),   32'h1);
        check("rst_out_valid", 32'(out_valid),  32'h0);
        check("rst_alu_op",    32'(alu_opcode), 32'h0);
        check("rst_alu_a",     alu_a,           32'h0);
        check("rst_flags_q",   32'(flags_q),    32'h0);
        check("rst_op_count",  32'(op_count),   32'h0);
        check("rst_halted",    32'(halted),     32'h0);
        rst_n = 1'b1;
        step();

        // ADD overflow to zero: C=1 S=0 O=1 Z=1
        offer(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("add_exec_valid",   32'(out_valid),  32'h0);
        check("add_exec_ready",   32'(in_ready),   32'h0);
        check("add_alu_op",       32'(alu_opcode), 32'h5);
        check("add_alu_a",        alu_a,           32'h8000_0000);
        step();
        check("add_resp_valid",   32'(out_valid),  32'h1);
        check("add_out_r",        out_r,           32'h0000_0000);
        check("add_out_flags",    32'(out_flags),  32'hB);
        check("add_out_err",      32'(out_err),    32'h0);
        step();
        check("add_done_valid",   32'(out_valid),  32'h0);
        check("add_flags_q",      32'(flags_q),    32'hB);
        check("add_op_count",     32'(op_count),   32'h1);
        check("add_idle_ready",   32'(in_ready),   32'h1);

        // SUB 0-1 with back-pressure for 5 cycles
        out_ready = 1'b0;
        offer(OP_SUB, 32'h0, 32'h1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("sub_hold_valid", 32'(out_valid),    32'h1);
            check("sub_hold_r",     out_r,             32'hFFFF_FFFF);
            check("sub_hold_s",     32'(out_flags[2]), 32'h1);
            check("sub_hold_z",     32'(out_flags[0]), 32'h0);
            check("sub_hold_ready", 32'(in_ready),     32'h0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("sub_done_valid", 32'(out_valid), 32'h0);
        check("sub_flags_q",    32'(flags_q),   32'hC);
        check("sub_op_count",   32'(op_count),  32'h2);

        // Illegal opcode 5'h1E
        offer(5'h1E, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        check("ill_alu_op",    32'(alu_opcode), 32'h0);
        step();
        check("ill_valid",     32'(out_valid),  32'h1);
        check("ill_err",       32'(out_err),    32'h1);
        check("ill_r",         out_r,           32'h0);
        check("ill_flags",     32'(out_flags),  32'h0);
        step();
        check("ill_flags_q",   32'(flags_q),    32'hC);
        check("ill_op_count",  32'(op_count),   32'h3);

        // OR then AND with chained operand A
        offer(OP_OR, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
        step();
        check("or_r",          out_r,           32'hFFFF_FFFF);
        check("or_err",        32'(out_err),    32'h0);
        step();
        offer(OP_AND, 32'h0, 32'h0000_1111, 1'b1);
`ifdef ALU_SEQ_CHAIN_EN
        check("and_chain_a",   alu_a,           32'hFFFF_FFFF);
        step();
        check("and_chain_r",   out_r,           32'h0000_1111);
        check("and_chain_fl",  32'(out_flags),  32'h0);
`else
        check("and_plain_a",   alu_a,           32'h0);
        step();
        check("and_plain_r",   out_r,           32'h0);
        check("and_plain_fl",  32'(out_flags),  32'h1);
`endif
        step();
        check("and_op_count",  32'(op_count),   32'h5);

        // Reset while a response is pending
        out_ready = 1'b0;
        offer(OP_ADD, 32'h1, 32'h2, 1'b0);
        step();
        check("rr_valid_before", 32'(out_valid), 32'h1);
        check("rr_r_before",     out_r,          32'h3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("rr_valid_after",  32'(out_valid), 32'h0);
        check("rr_op_count",     32'(op_count),  32'h0);
        check("rr_ready",        32'(in_ready),  32'h1);
        check("rr_out_r",        out_r,          32'h0);

        // SUB then NOP: NOP must leave flags_q alone
        offer(OP_SUB, 32'h0, 32'h1, 1'b0);
        step(); step();
        check("pre_nop_flags_q", 32'(flags_q),   32'hC);
        offer(OP_NOP, 32'h5, 32'h6, 1'b0);
        step();
        check("nop_r",           out_r,          32'h0);
        check("nop_err",         32'(out_err),   32'h0);
        step();
        check("nop_flags_q",     32'(flags_q),   32'hC);
        check("nop_op_count",    32'(op_count),  32'h2);

        // HLT with in_valid held high for 20 cycles
        in_valid = 1'b1; in_op = OP_HLT; in_a = 32'hDEAD_BEEF; in_b = 32'h1;
        step();
        check("hlt_halted",      32'(halted),     32'h1);
        for (int i = 0; i < 20; i++) begin
            check("hlt_ready",   32'(in_ready),   32'h0);
            check("hlt_valid",   32'(out_valid),  32'h0);
            step();
        end
        check("hlt_alu_op",      32'(alu_opcode), 32'h0);
        check("hlt_alu_a",       alu_a,           32'h5);
        check("hlt_op_count",    32'(op_count),   32'h2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("hrst_halted",     32'(halted),     32'h0);
        check("hrst_ready",      32'(in_ready),   32'h1);
        check("hrst_flags_q",    32'(flags_q),    32'h0);
        check("hrst_alu_a",      alu_a,           32'h0);
        check("hrst_alu_b",      alu_b,           32'h0);
        check("hrst_out_err",    32'(out_err),    32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
